rf68000_node_ram_arbiter: RTL and testbench
===========================================

Name: rf68000_node_ram_arbiter

Overview:
- Parametrised successor to the two-port node RAM arbiter in each rf68000 node.
- Arbitrates NCH WISHBONE-style masters (CPU, NIC, DMA, debug, ...) onto one synchronous node RAM port.
- Round-robin grant; configurable RAM read latency; faster write completion.
- Per-channel address window, and optional null-ack of out-of-window cycles so ring traffic cannot stall.

Parameters:
NCH, 2, number of master channels (1..8); channel 0 has first priority after reset
AW, 32, address width
DW, 32, data width; byte lanes SW = DW/8
RD_LAT, 3, RAM read latency in clocks (1..7)
WIN_MASK, 32'hFFF00000, address bits compared for a window hit
NULL_ACK, 2'b10, per-channel bit: ack out-of-window cycles with zero data

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
win_base  in  AW  window base per channel, packed NCH*AW (parent folds node id in)
m_cyc  in  NCH  cycle valid per channel
m_stb  in  NCH  strobe per channel
m_we  in  NCH  write enable per channel
m_sel  in  NCH*SW  byte selects, packed
m_adr  in  NCH*AW  addresses, packed
m_dato  in  NCH*DW  master write data, packed
m_ack  out  NCH  acknowledge per channel
m_dati  out  NCH*DW  read data to masters, packed
ram_en  out  1  RAM enable
ram_we  out  SW  RAM byte write enables
ram_adr  out  AW  RAM address
ram_dati  out  DW  RAM write data
ram_dato  in  DW  RAM read data
gnt  out  NCH  one-hot current grant, 0 when idle

Behaviour:
- Reset (async, rst_i high): m_ack=0, m_dati=0, ram_en=0, ram_we=0, ram_adr=0, ram_dati=0, gnt=0, state=IDLE, rr_last=NCH-1, cnt=0.
- Request: req[c] = m_cyc[c] & m_stb[c]. hit[c] = ((m_adr[c]^win_base[c]) & WIN_MASK)==0.
- States: IDLE, ACCESS, ACK.
- IDLE:
  - Pick the first c with req&hit, searching from rr_last+1 with wrap.
  - On a grant g: register gnt, ram_en=1, ram_adr, ram_dati, ram_we = {SW{m_we}} & m_sel; cnt = m_we ? 0 : RD_LAT-1; go to ACCESS.
- ACCESS:
  - Each clock, refresh ram_* from channel g.
  - cnt != 0: decrement.
  - cnt == 0: m_ack[g]=1; m_dati[g] = ram_dato on reads, 0 on writes; ram_en=0, ram_we=0; go to ACK.
- Latency, grant edge T0: write ack visible after edge T0+1; read ack after edge T0+RD_LAT. ram_dato is sampled at that edge.
- ACK:
  - Hold m_ack[g] until req[g] drops.
  - Then m_ack[g]=0, m_dati[g]=0, rr_last=g, gnt=0, go to IDLE.
  - A new grant is issued no earlier than the clock after IDLE is entered.
- Abort: if m_cyc[g] falls during ACCESS: ram_en=0, ram_we=0, no ack, rr_last=g, go to IDLE.
- Null ack:
  - Any channel with NULL_ACK[c]=1, req[c]=1, hit[c]=0 gets m_ack[c]=1, m_dati[c]=0 on the next edge, in any state, independent of the RAM.
  - The ack is held until req[c] drops, then cleared on the next edge.
  - Channels with NULL_ACK[c]=0 ignore out-of-window cycles (other slaves respond).
- Non-granted channels keep m_ack=0 and m_dati=0, except for null acks.
- Simultaneous requests: exactly one grant, per round-robin order. No channel waits more than NCH-1 grants.
- RD_LAT=1: read cnt starts at 0, behaving like a write but with data capture.
- Reset asserted mid-ACCESS: everything returns to reset values immediately; RAM write enables drop without waiting for a clock.

Test Plan:
- Reset then CPU (ch0) read hit at 0x00001000, RD_LAT=3, RAM model returns 0xDEADBEEF -> m_ack[0] rises 3 clocks after grant with m_dati[0]=0xDEADBEEF; ram_we=0 throughout.
- ch0 write 0x12345678, sel=4'b0011 -> ram_we=4'b0011 for one access cycle, ack on next edge, RAM holds 0x5678 in the low half only.
- ch0 and ch1 both requesting in-window reads continuously from reset -> grants alternate 0,1,0,1; each ack drops before the next gnt; no back-to-back grant without an IDLE clock.
- ch1 (NULL_ACK=1) reads 0xFE000000 outside its window while ch0 holds a read grant -> m_ack[1]=1 with 0x0 on the next edge; ch0 completes unaffected.
- ch0 drops m_cyc one clock after grant with RD_LAT=3 -> ram_en=0 next edge, no m_ack[0]; ch1's pending request is granted within 2 clocks.
- rst_i asserted asynchronously mid-write -> ram_we=0 and m_ack=0 before the next clk_i edge, state IDLE, next grant goes to ch0.

Source files
------------

// File: rtl/rf68000_node_ram_arbiter.sv
// Round-robin arbiter multiplexing NCH WISHBONE-style masters onto one synchronous node RAM port,
// with per-channel address windows and optional null acks for out-of-window cycles.
module rf68000_node_ram_arbiter #(
    parameter int              NCH      = 2,
    parameter int              AW       = 32,
    parameter int              DW       = 32,
    parameter int              RD_LAT   = 3,
    parameter logic [AW-1:0]   WIN_MASK = AW'(32'hFFF00000),
    parameter logic [NCH-1:0]  NULL_ACK = NCH'(2'b10)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NCH*AW-1:0]     win_base,
    input  logic [NCH-1:0]        m_cyc,
    input  logic [NCH-1:0]        m_stb,
    input  logic [NCH-1:0]        m_we,
    input  logic [NCH*(DW/8)-1:0] m_sel,
    input  logic [NCH*AW-1:0]     m_adr,
    input  logic [NCH*DW-1:0]     m_dato,
    output logic [NCH-1:0]        m_ack,
    output logic [NCH*DW-1:0]     m_dati,
    output logic                  ram_en,
    output logic [DW/8-1:0]       ram_we,
    output logic [AW-1:0]         ram_adr,
    output logic [DW-1:0]         ram_dati,
    input  logic [DW-1:0]         ram_dato,
    output logic [NCH-1:0]        gnt
);

    localparam int SW = DW / 8;
    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

    state_t          state, state_n;
    logic [IW-1:0]   g, g_n;
    logic [IW-1:0]   rr_last, rr_last_n;
    logic [2:0]      cnt, cnt_n;
    logic [NCH-1:0]  gnt_n, ack_n;
    logic [NCH*DW-1:0] dati_n;
    logic            ram_en_n;
    logic [SW-1:0]   ram_we_n;
    logic [AW-1:0]   ram_adr_n;
    logic [DW-1:0]   ram_dati_n;

    logic [NCH-1:0]  req, hit, nul;
    logic            pick_valid;
    logic [IW-1:0]   pick, ch;
    logic            ch_we;
    logic [SW-1:0]   ch_sel;
    logic [AW-1:0]   ch_adr;
    logic [DW-1:0]   ch_dat;

    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            req[c] = m_cyc[c] & m_stb[c];
            hit[c] = ((m_adr[c*AW +: AW] ^ win_base[c*AW +: AW]) & WIN_MASK) == '0;
            nul[c] = NULL_ACK[c] & req[c] & ~hit[c];
        end
    end

    // Round-robin search starts just after the last channel served.
    always_comb begin
        int idx;
        idx        = 0;
        pick_valid = 1'b0;
        pick       = '0;
        for (int i = 1; i <= NCH; i++) begin
            idx = (int'(rr_last) + i) % NCH;
            if (!pick_valid && req[IW'(idx)] && hit[IW'(idx)]) begin
                pick_valid = 1'b1;
                pick       = IW'(idx);
            end
        end
    end

    // In IDLE the candidate channel drives the RAM port; otherwise the granted one does.
    assign ch     = (state == IDLE) ? pick : g;
    assign ch_we  = m_we[ch];
    assign ch_sel = m_sel[ch*SW +: SW];
    assign ch_adr = m_adr[ch*AW +: AW];
    assign ch_dat = m_dato[ch*DW +: DW];

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_n    = state;
        g_n        = g;
        rr_last_n  = rr_last;
        cnt_n      = cnt;
        gnt_n      = gnt;
        ack_n      = m_ack;
        dati_n     = m_dati;
        ram_en_n   = ram_en;
        ram_we_n   = ram_we;
        ram_adr_n  = ram_adr;
        ram_dati_n = ram_dati;

        // Channels not owning the RAM see only their null acks.
        for (int c = 0; c < NCH; c++) begin
            if (state == IDLE || IW'(c) != g) begin
                ack_n[c]              = nul[c];
                dati_n[c*DW +: DW]    = '0;
            end
        end

        case (state)
            IDLE: begin
                if (pick_valid) begin
                    g_n        = pick;
                    gnt_n      = '0;
                    gnt_n[pick] = 1'b1;
                    ram_en_n   = 1'b1;
                    ram_adr_n  = ch_adr;
                    ram_dati_n = ch_dat;
                    ram_we_n   = {SW{ch_we}} & ch_sel;
                    cnt_n      = ch_we ? 3'd0 : 3'(RD_LAT - 1);
                    state_n    = ACCESS;
                end
            end
            ACCESS: begin
                if (!m_cyc[g]) begin
                    ram_en_n  = 1'b0;
                    ram_we_n  = '0;
                    rr_last_n = g;
                    gnt_n     = '0;
                    state_n   = IDLE;
                end else begin
                    ram_adr_n  = ch_adr;
                    ram_dati_n = ch_dat;
                    ram_we_n   = {SW{ch_we}} & ch_sel;
                    if (cnt != 3'd0) begin
                        cnt_n = cnt - 3'd1;
                    end else begin
                        ack_n[g]           = 1'b1;
                        dati_n[g*DW +: DW] = ch_we ? '0 : ram_dato;
                        ram_en_n           = 1'b0;
                        ram_we_n           = '0;
                        state_n            = ACK;
                    end
                end
            end
            ACK: begin
                if (!req[g]) begin
                    ack_n[g]           = 1'b0;
                    dati_n[g*DW +: DW] = '0;
                    rr_last_n          = g;
                    gnt_n              = '0;
                    state_n            = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            g        <= '0;
            rr_last  <= IW'(NCH - 1);
            cnt      <= '0;
            gnt      <= '0;
            m_ack    <= '0;
            m_dati   <= '0;
            ram_en   <= 1'b0;
            ram_we   <= '0;
            ram_adr  <= '0;
            ram_dati <= '0;
        end else begin
            state    <= state_n;
            g        <= g_n;
            rr_last  <= rr_last_n;
            cnt      <= cnt_n;
            gnt      <= gnt_n;
            m_ack    <= ack_n;
            m_dati   <= dati_n;
            ram_en   <= ram_en_n;
            ram_we   <= ram_we_n;
            ram_adr  <= ram_adr_n;
            ram_dati <= ram_dati_n;
        end
    end

endmodule

// File: tb/tb_rf68000_node_ram_arbiter.sv
// Bench for rf68000_node_ram_arbiter: directed scenarios plus random two-master traffic,
// checked against a word-level memory model and the grant/ack latency rules.
module tb_rf68000_node_ram_arbiter;

    localparam int NCH    = 2;
    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int SW     = DW / 8;
    localparam int RD_LAT = 3;

    logic                clk_i, rst_i;
    logic [NCH*AW-1:0]   win_base;
    logic [NCH-1:0]      m_cyc, m_stb, m_we;
    logic [NCH*SW-1:0]   m_sel;
    logic [NCH*AW-1:0]   m_adr;
    logic [NCH*DW-1:0]   m_dato;
    logic [NCH-1:0]      m_ack;
    logic [NCH*DW-1:0]   m_dati;
    logic                ram_en;
    logic [SW-1:0]       ram_we;
    logic [AW-1:0]       ram_adr;
    logic [DW-1:0]       ram_dati;
    logic [DW-1:0]       ram_dato;
    logic [NCH-1:0]      gnt;

    rf68000_node_ram_arbiter #(
        .NCH(NCH), .AW(AW), .DW(DW), .RD_LAT(RD_LAT),
        .WIN_MASK(32'hFFF00000), .NULL_ACK(2'b10)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .win_base(win_base),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_sel(m_sel),
        .m_adr(m_adr), .m_dato(m_dato), .m_ack(m_ack), .m_dati(m_dati),
        .ram_en(ram_en), .ram_we(ram_we), .ram_adr(ram_adr),
        .ram_dati(ram_dati), .ram_dato(ram_dato), .gnt(gnt)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Synchronous byte-writable RAM; preload port used only while the arbiter is idle.
    logic [DW-1:0] ram_mem [0:4095];
    logic          pre_en;
    logic [11:0]   pre_idx;
    logic [DW-1:0] pre_dat;

    always @(posedge clk_i) begin
        if (ram_en) begin
            for (int b = 0; b < SW; b++)
                if (ram_we[b]) ram_mem[ram_adr[13:2]][b*8 +: 8] <= ram_dati[b*8 +: 8];
            ram_dato <= ram_mem[ram_adr[13:2]];
        end else if (pre_en) begin
            ram_mem[pre_idx] <= pre_dat;
        end
    end

    // Records each fresh grant with the grant and ack seen just before it.
    bit             mon_en;
    logic [NCH-1:0] prev_gnt;
    logic [NCH-1:0] mon_gnt_q[$];
    logic [NCH-1:0] mon_prev_q[$];
    logic [NCH-1:0] mon_ack_q[$];

    always @(negedge clk_i) begin
        if (mon_en && gnt != '0 && gnt != prev_gnt) begin
            mon_gnt_q.push_back(gnt);
            mon_prev_q.push_back(prev_gnt);
            mon_ack_q.push_back(m_ack);
        end
        prev_gnt <= gnt;
    end

    logic [DW-1:0] ref_mem [0:4095];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic preload(input int idx, input logic [DW-1:0] dat);
        pre_en  = 1'b1;
        pre_idx = 12'(idx);
        pre_dat = dat;
        ref_mem[idx] = dat;
        tick();
        pre_en = 1'b0;
    endtask

    task automatic reset_dut();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
    endtask

    task automatic req_on(input int c, input logic we, input logic [AW-1:0] adr,
                          input logic [SW-1:0] sel, input logic [DW-1:0] dat);
        m_we[c]             = we;
        m_adr[c*AW +: AW]   = adr;
        m_sel[c*SW +: SW]   = sel;
        m_dato[c*DW +: DW]  = dat;
        m_cyc[c]            = 1'b1;
        m_stb[c]            = 1'b1;
    endtask

    task automatic req_off(input int c);
        m_cyc[c] = 1'b0;
        m_stb[c] = 1'b0;
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] dat,
                                            input logic [SW-1:0] sel);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < SW; b++)
            if (sel[b]) r[b*8 +: 8] = dat[b*8 +: 8];
        return r;
    endfunction

    // One complete master cycle: writes ack one clock after grant, reads RD_LAT clocks after,
    // null acks one clock after the request.
    task automatic xfer(input int c, input logic we, input logic [AW-1:0] adr,
                        input logic [SW-1:0] sel, input logic [DW-1:0] dat, input bit nul);
        logic [DW-1:0] exp_d;
        int idx, lat, wait_cnt, exp_lat;
        idx   = int'(adr[13:2]);
        exp_d = (we || nul) ? '0 : ref_mem[idx];
        req_on(c, we, adr, sel, dat);
        wait_cnt = 0;
        lat      = 0;
        if (!nul) begin
            while (!gnt[c] && wait_cnt < 60) begin
                tick();
                wait_cnt++;
            end
            check($sformatf("ch%0d_grant", c), 64'(gnt[c]), 64'd1);
            exp_lat = we ? 1 : RD_LAT;
        end else begin
            exp_lat = 1;
        end
        while (!m_ack[c] && lat < 20) begin
            tick();
            lat++;
        end
        check($sformatf("ch%0d_ack_lat we=%0d nul=%0d", c, we, nul), 64'(lat), 64'(exp_lat));
        check($sformatf("ch%0d_data adr=%0h", c, adr), 64'(m_dati[c*DW +: DW]), 64'(exp_d));
        if (we && !nul) ref_mem[idx] = merge(ref_mem[idx], dat, sel);
        req_off(c);
        tick();
        check($sformatf("ch%0d_ack_clear", c), 64'(m_ack[c]), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i    = 1'b1;
        win_base = {32'h0010_0000, 32'h0000_0000};
        m_cyc = '0; m_stb = '0; m_we = '0; m_sel = '0; m_adr = '0; m_dato = '0;
        pre_en = 1'b0; pre_idx = '0; pre_dat = '0; mon_en = 1'b0;

        // Reset state, with RAM preloads done while reset holds the arbiter.
        tick();
        check("rst_m_ack", 64'(m_ack), 64'd0);
        check("rst_m_dati", 64'(m_dati), 64'd0);
        check("rst_ram_en", 64'(ram_en), 64'd0);
        check("rst_ram_we", 64'(ram_we), 64'd0);
        check("rst_ram_adr", 64'(ram_adr), 64'd0);
        check("rst_ram_dati", 64'(ram_dati), 64'd0);
        check("rst_gnt", 64'(gnt), 64'd0);
        preload(12'h400, 32'hDEADBEEF);
        preload(12'h041, 32'hAAAAAAAA);
        preload(12'h0C0, 32'h0C0C0C0C);
        preload(12'h0C1, 32'h1C1C1C1C);
        rst_i = 1'b0;

        // ch0 in-window read.
        req_on(0, 1'b0, 32'h0000_1000, 4'hF, '0);
        tick();
        check("rd_gnt", 64'(gnt), 64'b01);
        check("rd_ram_en", 64'(ram_en), 64'd1);
        check("rd_ram_adr", 64'(ram_adr), 64'h1000);
        for (int k = 1; k < RD_LAT; k++) begin
            tick();
            check("rd_early_ack", 64'(m_ack), 64'd0);
            check("rd_ram_we", 64'(ram_we), 64'd0);
        end
        tick();
        check("rd_ack", 64'(m_ack), 64'b01);
        check("rd_data", 64'(m_dati[31:0]), 64'hDEADBEEF);
        req_off(0);
        tick();
        check("rd_release_ack", 64'(m_ack), 64'd0);
        check("rd_release_gnt", 64'(gnt), 64'd0);
        check("rd_release_dati", 64'(m_dati), 64'd0);

        // ch0 partial write.
        req_on(0, 1'b1, 32'h0000_0104, 4'b0011, 32'h12345678);
        tick();
        check("wr_gnt", 64'(gnt), 64'b01);
        check("wr_ram_we", 64'(ram_we), 64'b0011);
        check("wr_ram_dati", 64'(ram_dati), 64'h12345678);
        tick();
        check("wr_ack", 64'(m_ack), 64'b01);
        check("wr_dati_zero", 64'(m_dati), 64'd0);
        check("wr_ram_we_off", 64'(ram_we), 64'd0);
        check("wr_ram_content", 64'(ram_mem[12'h041]), 64'hAAAA5678);
        ref_mem[12'h041] = 32'hAAAA5678;
        req_off(0);
        tick();

        // ch0 has no null ack: an out-of-window cycle is simply ignored.
        req_on(0, 1'b0, 32'h0010_0000, 4'hF, '0);
        repeat (4) tick();
        check("ch0_oow_ack", 64'(m_ack), 64'd0);
        check("ch0_oow_gnt", 64'(gnt), 64'd0);
        req_off(0);
        tick();

        // Both channels requesting from reset: strict alternation with an idle clock between.
        reset_dut();
        mon_gnt_q.delete(); mon_prev_q.delete(); mon_ack_q.delete();
        mon_en = 1'b1;
        fork
            begin for (int k = 0; k < 3; k++) xfer(0, 1'b0, 32'h0000_0300, 4'hF, '0, 1'b0); end
            begin for (int k = 0; k < 3; k++) xfer(1, 1'b0, 32'h0010_0304, 4'hF, '0, 1'b0); end
        join
        mon_en = 1'b0;
        check("alt_count", 64'(mon_gnt_q.size()), 64'd6);
        for (int k = 0; k < mon_gnt_q.size(); k++) begin
            check($sformatf("alt_order%0d", k), 64'(mon_gnt_q[k]), (k % 2 == 0) ? 64'b01 : 64'b10);
            check($sformatf("alt_idle%0d", k), 64'(mon_prev_q[k]), 64'd0);
            check($sformatf("alt_ack_low%0d", k), 64'(mon_ack_q[k]), 64'd0);
        end

        // ch1 null ack while ch0 holds a read grant.
        req_on(0, 1'b0, 32'h0000_1000, 4'hF, '0);
        tick();
        check("nul_gnt0", 64'(gnt), 64'b01);
        req_on(1, 1'b0, 32'hFE00_0000, 4'hF, '0);
        tick();
        check("nul_ack1", 64'(m_ack), 64'b10);
        check("nul_dati1", 64'(m_dati[63:32]), 64'd0);
        tick();
        check("nul_ch0_wait", 64'(m_ack[0]), 64'd0);
        tick();
        check("nul_ch0_ack", 64'(m_ack), 64'b11);
        check("nul_ch0_data", 64'(m_dati[31:0]), 64'hDEADBEEF);
        req_off(1);
        tick();
        check("nul_ack1_clear", 64'(m_ack), 64'b01);
        req_off(0);
        tick();
        check("nul_all_clear", 64'(m_ack), 64'd0);

        // ch0 abort one clock after grant; pending ch1 takes over.
        reset_dut();
        req_on(0, 1'b0, 32'h0000_1000, 4'hF, '0);
        req_on(1, 1'b0, 32'h0010_0304, 4'hF, '0);
        tick();
        check("abt_gnt0", 64'(gnt), 64'b01);
        req_off(0);
        tick();
        check("abt_ram_en", 64'(ram_en), 64'd0);
        check("abt_no_ack", 64'(m_ack), 64'd0);
        tick();
        check("abt_gnt1", 64'(gnt), 64'b10);
        repeat (RD_LAT) tick();
        check("abt_ch1_ack", 64'(m_ack), 64'b10);
        check("abt_ch1_data", 64'(m_dati[63:32]), 64'(ref_mem[12'h0C1]));
        req_off(1);
        tick();

        // Asynchronous reset in the middle of a ch1 write.
        preload(12'h082, 32'h11111111);
        req_on(1, 1'b1, 32'h0010_0208, 4'hF, 32'hCAFEF00D);
        tick();
        check("ars_ram_we", 64'(ram_we), 64'hF);
        #2 rst_i = 1'b1;
        #1;
        check("ars_ram_we_off", 64'(ram_we), 64'd0);
        check("ars_ram_en_off", 64'(ram_en), 64'd0);
        check("ars_ack_off", 64'(m_ack), 64'd0);
        check("ars_gnt_off", 64'(gnt), 64'd0);
        req_off(1);
        tick();
        rst_i = 1'b0;
        check("ars_no_write", 64'(ram_mem[12'h082]), 64'h11111111);
        req_on(0, 1'b0, 32'h0000_1000, 4'hF, '0);
        req_on(1, 1'b0, 32'h0010_0304, 4'hF, '0);
        tick();
        check("ars_next_gnt", 64'(gnt), 64'b01);
        req_off(0);
        req_off(1);
        reset_dut();

        // Random traffic from both masters over private regions; ch1 also strays out of window.
        for (int k = 0; k < 16; k++) begin
            preload(12'h040 + k, $urandom);
            preload(12'h080 + k, $urandom);
        end
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    xfer(0, 1'($urandom), 32'h0000_0100 + 32'(4 * $urandom_range(0, 15)),
                         4'($urandom), $urandom, 1'b0);
                    repeat ($urandom_range(0, 3)) tick();
                end
            end
            begin
                for (int k = 0; k < 40; k++) begin
                    if ($urandom_range(0, 3) == 0)
                        xfer(1, 1'($urandom), 32'hF000_0000 | 32'($urandom_range(0, 255) << 2),
                             4'hF, $urandom, 1'b1);
                    else
                        xfer(1, 1'($urandom), 32'h0010_0200 + 32'(4 * $urandom_range(0, 15)),
                             4'($urandom), $urandom, 1'b0);
                    repeat ($urandom_range(0, 3)) tick();
                end
            end
        join
        for (int k = 0; k < 16; k++) begin
            check($sformatf("rnd_mem0_%0d", k), 64'(ram_mem[12'h040 + k]), 64'(ref_mem[12'h040 + k]));
            check($sformatf("rnd_mem1_%0d", k), 64'(ram_mem[12'h080 + k]), 64'(ref_mem[12'h080 + k]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
